// File: rtl/ccff_loader.sv
// ccff_loader: writer end of a DFF configuration chain.
// Takes WORD_W-bit words from a host over valid/ready and shifts exactly
// CHAIN_LEN bits, LSB-first, into the chain head. One bit is shifted per
// cycle with ccff_shift_en high; with no bit to shift, ccff_shift_en is low
// and ccff_head holds its last value.
//
// Ports:
//   prog_clk, prog_reset_n  clock, asynchronous active-low reset
//   start                   one-cycle pulse, begins a load when idle
//   s_data/s_valid/s_ready  host word stream (s_ready decoded from state)
//   ccff_head, ccff_shift_en  serial bit and shift enable to the chain
//   ccff_tail               serial bit from the chain tail
//   busy, done, bits_loaded load status
//
// Optional build macro CCFF_LOADER_VERIFY_EN adds input verify and the
// outputs mismatch / mismatch_cnt. A verify load compares ccff_tail with
// ccff_head on every shift. The tail then carries the bit from the same
// index of the previous load.
module ccff_loader #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned CHAIN_LEN = 1024,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_loaded
`ifdef CCFF_LOADER_VERIFY_EN
  ,
  input  logic              verify,
  output logic              mismatch,
  output logic [CNT_W-1:0]  mismatch_cnt
`endif
);

  localparam int unsigned NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int unsigned REM_BITS  = CHAIN_LEN % WORD_W;
  localparam int unsigned LAST_BITS = (REM_BITS == 0) ? WORD_W : REM_BITS;
  localparam int unsigned WR_W      = $clog2(NWORDS + 1);
  localparam int unsigned BL_W      = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;      // word being shifted, bit 0 next
  logic [BL_W-1:0]   left_q, left_d;    // unshifted bits left in buf_q
  logic [WR_W-1:0]   words_q, words_d;  // words still to accept
  logic              head_q, head_d;
  logic              shen_q, shen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_c;

`ifdef CCFF_LOADER_VERIFY_EN
  logic              verify_q, verify_d;
  logic              mism_q, mism_d;
  logic [CNT_W-1:0]  mcnt_q, mcnt_d;
`else
  logic              unused_tail;
  assign unused_tail = ccff_tail;
`endif

  // Ready when the buffer is empty or its last bit goes out this cycle.
  // This lets back-to-back words shift without a bubble.
  assign ready_c = (state_q == SHIFT) && (words_q != '0) &&
                   ((left_q == '0) || (left_q == BL_W'(1)));

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    left_d  = left_q;
    words_d = words_q;
    head_d  = head_q;
    shen_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
`ifdef CCFF_LOADER_VERIFY_EN
    verify_d = verify_q;
    mism_d   = mism_q;
    mcnt_d   = mcnt_q;
    // Compare on the cycle the chain actually shifts.
    if (verify_q && shen_q && (ccff_tail != head_q)) begin
      mism_d = 1'b1;
      if (mcnt_q != {CNT_W{1'b1}}) mcnt_d = mcnt_q + CNT_W'(1);
    end
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          busy_d  = 1'b1;
          cnt_d   = '0;
          left_d  = '0;
          words_d = WR_W'(NWORDS);
`ifdef CCFF_LOADER_VERIFY_EN
          verify_d = verify;
          mism_d   = 1'b0;
          mcnt_d   = '0;
`endif
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        if (cnt_q == CNT_W'(CHAIN_LEN)) begin
          // The last shift is on the chain this cycle; finish next cycle.
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          if (left_q != '0) begin
            shen_d = 1'b1;
            head_d = buf_q[0];
            buf_d  = buf_q >> 1;
            left_d = left_q - BL_W'(1);
            cnt_d  = cnt_q + CNT_W'(1);
          end
          if (s_valid && ready_c) begin
            // A short final word keeps only its low LAST_BITS bits.
            buf_d   = s_data;
            words_d = words_q - WR_W'(1);
            left_d  = (words_q == WR_W'(1)) ? BL_W'(LAST_BITS) : BL_W'(WORD_W);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      left_q  <= '0;
      words_q <= '0;
      head_q  <= 1'b0;
      shen_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef CCFF_LOADER_VERIFY_EN
      verify_q <= 1'b0;
      mism_q   <= 1'b0;
      mcnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      left_q  <= left_d;
      words_q <= words_d;
      head_q  <= head_d;
      shen_q  <= shen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
`ifdef CCFF_LOADER_VERIFY_EN
      verify_q <= verify_d;
      mism_q   <= mism_d;
      mcnt_q   <= mcnt_d;
`endif
    end
  end

  assign s_ready       = ready_c;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shen_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign bits_loaded   = cnt_q;
`ifdef CCFF_LOADER_VERIFY_EN
  assign mismatch      = mism_q;
  assign mismatch_cnt  = mcnt_q;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Testbench for ccff_loader: a 17-bit chain instance driven from a vector
// table plus directed sequences, and a 16-bit (exact multiple) instance.
module tb_ccff_loader;
  localparam int unsigned WW  = 8;
  localparam int unsigned CL  = 17;
  localparam int unsigned CW  = $clog2(CL + 1);
  localparam int unsigned CL2 = 16;
  localparam int unsigned CW2 = $clog2(CL2 + 1);

  logic prog_clk = 1'b0;
  logic prog_reset_n = 1'b0;

  logic          start = 1'b0;
  logic [WW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done;
  logic [CW-1:0] bits_loaded;

  logic           start_b = 1'b0;
  logic [WW-1:0]  s_data_b = '0;
  logic           s_valid_b = 1'b0;
  logic           s_ready_b, ccff_head_b, ccff_shift_en_b, busy_b, done_b;
  logic           ccff_tail_b = 1'b0;
  logic [CW2-1:0] bits_loaded_b;

`ifdef CCFF_LOADER_VERIFY_EN
  logic          verify = 1'b0;
  logic          mismatch;
  logic [CW-1:0] mismatch_cnt;
  logic           verify_b = 1'b0;
  logic           mismatch_b;
  logic [CW2-1:0] mismatch_cnt_b;
`endif

  always #5 prog_clk = ~prog_clk;

  ccff_loader #(.WORD_W(WW), .CHAIN_LEN(CL), .CNT_W(CW)) dut (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .bits_loaded(bits_loaded)
`ifdef CCFF_LOADER_VERIFY_EN
    , .verify(verify), .mismatch(mismatch), .mismatch_cnt(mismatch_cnt)
`endif
  );

  ccff_loader #(.WORD_W(WW), .CHAIN_LEN(CL2), .CNT_W(CW2)) dut_b (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start_b),
    .s_data(s_data_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
    .ccff_head(ccff_head_b), .ccff_shift_en(ccff_shift_en_b), .ccff_tail(ccff_tail_b),
    .busy(busy_b), .done(done_b), .bits_loaded(bits_loaded_b)
`ifdef CCFF_LOADER_VERIFY_EN
    , .verify(verify_b), .mismatch(mismatch_b), .mismatch_cnt(mismatch_cnt_b)
`endif
  );

  // 17-DFF chain model: head enters bit 0, tail is the top bit.
  logic [CL-1:0] chain = '0;
  always @(posedge prog_clk) if (ccff_shift_en === 1'b1) chain <= {chain[CL-2:0], ccff_head};
  assign ccff_tail = chain[CL-1];

  // Shift / done logs, sampled on the edge where the chain shifts.
  logic sh_bit [512];
  int   sh_cyc [512];
  int   n_sh = 0, n_done = 0, cyc = 0;
  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    if (ccff_shift_en === 1'b1 && n_sh < 512) begin
      sh_bit[n_sh] <= ccff_head;
      sh_cyc[n_sh] <= cyc;
      n_sh <= n_sh + 1;
    end
    if (done === 1'b1) n_done <= n_done + 1;
  end

  logic sh_bit_b [64];
  int   n_sh_b = 0;
  always @(posedge prog_clk) begin
    if (ccff_shift_en_b === 1'b1 && n_sh_b < 64) begin
      sh_bit_b[n_sh_b] <= ccff_head_b;
      n_sh_b <= n_sh_b + 1;
    end
  end

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Start a load and feed three words; gap = idle cycles held after s_ready
  // rises between words. Returns when done is seen, after rst_after shifts
  // (if nonzero), or on timeout.
  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                          input int gap, input bit mid_start, input int rst_after,
                          output int base);
    logic [7:0] wl [3];
    int acc, hold, cyc_l;
    bit pulsed;
    wl[0] = w0; wl[1] = w1; wl[2] = w2;
    acc = 0; hold = 0; cyc_l = 0; pulsed = 1'b0;
    @(negedge prog_clk);
    base  = n_sh;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    while (done !== 1'b1 && cyc_l < 300 && !(rst_after > 0 && (n_sh - base) >= rst_after)) begin
      start = 1'b0;
      if (mid_start && acc == 2 && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      if (acc >= 3) s_valid = 1'b0;
      else if (hold > 0) begin
        s_valid = 1'b0;
        if (s_ready === 1'b1) hold--;
      end else begin
        s_valid = 1'b1;
        s_data  = wl[acc];
        if (s_ready === 1'b1) begin
          acc++;
          hold = gap;
        end
      end
      @(negedge prog_clk);
      cyc_l++;
    end
    start   = 1'b0;
    s_valid = 1'b0;
  endtask

  // Checks made in the done cycle of a full load and one cycle after it.
  task automatic check_load(input string tag, input int base, input int nd0,
                            input logic [16:0] exp, input int span);
    logic [16:0] got, exp_chain;
    for (int i = 0; i < 17; i++) begin
      got[i] = sh_bit[base + i];
      exp_chain[16 - i] = exp[i];
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_bits_loaded"}, 32'(bits_loaded), 32'(CL));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check({tag, "_ready_in_done"}, 32'(s_ready), 32'd0);
    check({tag, "_shift_count"}, 32'(n_sh - base), 32'(CL));
    check({tag, "_stream"}, 32'(got), 32'(exp));
    check({tag, "_span"}, 32'(sh_cyc[base + 16] - sh_cyc[base]), 32'(span));
    check({tag, "_chain"}, 32'(chain), 32'(exp_chain));
    @(negedge prog_clk);
    check({tag, "_done_width"}, 32'(n_done - nd0), 32'd1);
    check({tag, "_shift_after_done"}, 32'(n_sh - base), 32'(CL));
  endtask

  // CHAIN_LEN=16 instance: words keep being offered; only two may be taken.
  task automatic run_exact();
    logic [7:0]  wl [3];
    logic [15:0] got;
    int acc, cyc_l, base;
    wl[0] = 8'h11; wl[1] = 8'h22; wl[2] = 8'h33;
    acc = 0; cyc_l = 0;
    @(negedge prog_clk);
    base    = n_sh_b;
    start_b = 1'b1;
    @(negedge prog_clk);
    start_b = 1'b0;
    while (done_b !== 1'b1 && cyc_l < 200) begin
      s_valid_b = 1'b1;
      s_data_b  = wl[(acc > 2) ? 2 : acc];
      if (s_ready_b === 1'b1) acc++;
      @(negedge prog_clk);
      cyc_l++;
    end
    for (int i = 0; i < 16; i++) got[i] = sh_bit_b[base + i];
    check("x16_done", 32'(done_b), 32'd1);
    check("x16_bits_loaded", 32'(bits_loaded_b), 32'(CL2));
    check("x16_shift_count", 32'(n_sh_b - base), 32'(CL2));
    check("x16_stream", 32'(got), 32'h2211);
    repeat (6) begin
      if (s_ready_b === 1'b1) acc++;
      @(negedge prog_clk);
    end
    check("x16_words_accepted", 32'(acc), 32'd2);
    s_valid_b = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  w0, w1, w2;
    int          gap;
    bit          mid_start;
    logic [16:0] exp;
    int          span;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int base, nd0;
    // Stream bit i = i-th bit shifted; span = cycles from first to last shift.
    tbl[0] = '{8'hA5, 8'h3C, 8'hFF, 0, 1'b0, 17'h13CA5, 16};
    tbl[1] = '{8'hA5, 8'h3C, 8'hFF, 5, 1'b0, 17'h13CA5, 26};
    tbl[2] = '{8'h12, 8'h34, 8'hFE, 0, 1'b1, 17'h03412, 16};
    tbl[3] = '{8'hFF, 8'h00, 8'h01, 2, 1'b0, 17'h100FF, 20};

    repeat (2) @(negedge prog_clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_head", 32'(ccff_head), 32'd0);
    check("rst_shift_en", 32'(ccff_shift_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bits_loaded", 32'(bits_loaded), 32'd0);
    prog_reset_n = 1'b1;

    for (int r = 0; r < 4; r++) begin
      nd0 = n_done;
      run_load(tbl[r].w0, tbl[r].w1, tbl[r].w2, tbl[r].gap, tbl[r].mid_start, 0, base);
      check_load($sformatf("row%0d", r), base, nd0, tbl[r].exp, tbl[r].span);
    end

    // Words offered in IDLE are neither accepted nor shifted.
    nd0 = n_sh;
    s_valid = 1'b1;
    s_data  = 8'h5A;
    repeat (4) @(negedge prog_clk);
    check("idle_s_ready", 32'(s_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_no_shift", 32'(n_sh - nd0), 32'd0);
    check("idle_bits_loaded", 32'(bits_loaded), 32'(CL));
    s_valid = 1'b0;

    // Reset after 9 shifts, then a complete load.
    run_load(8'hA5, 8'h3C, 8'hFF, 0, 1'b0, 9, base);
    check("pre_rst_shifts", 32'(n_sh - base), 32'd9);
    begin
      logic [8:0] first9;
      for (int i = 0; i < 9; i++) first9[i] = sh_bit[base + i];
      check("pre_rst_stream", 32'(first9), 32'h0A5);
    end
    nd0 = n_done;
    prog_reset_n = 1'b0;
    #1;
    check("mid_rst_s_ready", 32'(s_ready), 32'd0);
    check("mid_rst_head", 32'(ccff_head), 32'd0);
    check("mid_rst_shift_en", 32'(ccff_shift_en), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_bits_loaded", 32'(bits_loaded), 32'd0);
    @(negedge prog_clk);
    @(negedge prog_clk);
    check("mid_rst_no_done", 32'(n_done - nd0), 32'd0);
    prog_reset_n = 1'b1;
    nd0 = n_done;
    run_load(8'hA5, 8'h3C, 8'hFF, 0, 1'b0, 0, base);
    check_load("reload", base, nd0, 17'h13CA5, 16);

    run_exact();

`ifdef CCFF_LOADER_VERIFY_EN
    verify = 1'b0;
    nd0 = n_done;
    run_load(8'hA5, 8'h3C, 8'h01, 0, 1'b0, 0, base);
    check_load("vref", base, nd0, 17'h1_3CA5, 16);
    verify = 1'b1;
    run_load(8'hA5, 8'h3C, 8'h01, 0, 1'b0, 0, base);
    check("vsame_done", 32'(done), 32'd1);
    check("vsame_mismatch", 32'(mismatch), 32'd0);
    check("vsame_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
    run_load(8'hA4, 8'h3C, 8'h01, 0, 1'b0, 0, base);
    check("vdiff_done", 32'(done), 32'd1);
    check("vdiff_mismatch", 32'(mismatch), 32'd1);
    check("vdiff_mismatch_cnt", 32'(mismatch_cnt), 32'd1);
    verify = 1'b0;
    repeat (3) @(negedge prog_clk);
    check("vdiff_stable_mismatch", 32'(mismatch), 32'd1);
    check("vdiff_stable_cnt", 32'(mismatch_cnt), 32'd1);
    check("x16_no_mismatch", 32'(mismatch_b), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, compared %0d, want summary", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
